// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared definitions for the RV523 program-counter stage.
//   RV523_XLEN          default address width
//   RV523_RESET_VECTOR  default PC after reset (bits [1:0] must be zero)
//   pc_state_e          HOLD / RUN state encoding (ST_HOLD=0, ST_RUN=1)
//   nand2 / mux2_nand   NAND-cell helpers; all steering logic is expressed
//                       through these so it maps onto the NAND cell library.
package pc_unit_pkg;

    localparam int          RV523_XLEN         = 32;
    localparam int unsigned RV523_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

    // 2:1 mux from three NANDs plus the select inverter: sel=0 -> a, sel=1 -> b.
    function automatic logic mux2_nand(input logic sel, input logic a, input logic b);
        return nand2(nand2(a, ~sel), nand2(b, sel));
    endfunction

endpackage

// File: rtl/pc_incr.sv
// pc_incr: combinational ripple incrementer (+1) of width W.
//   a_i  input  [W-1:0]  operand (PC word index, i.e. PC[XLEN-1:2])
//   y_o  output [W-1:0]  a_i + 1, carry-out dropped (wraps to zero)
// Each bit is a half adder built from NAND cells; the chain's carry-in is
// the constant 1 that represents "+4" on the byte address.
module pc_incr
    import pc_unit_pkg::*;
#(
    parameter int W = 30
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    // carry[gi] is the carry into bit gi; carry[0] is the injected +1.
    logic [W-1:0] carry;
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_ha
            logic n_ac;
            assign n_ac    = nand2(a_i[gi], carry[gi]);
            // NAND XOR: sum = a ^ c
            assign y_o[gi] = nand2(nand2(a_i[gi], n_ac), nand2(carry[gi], n_ac));
            // Carry out of the top bit is intentionally not produced.
            if (gi < W - 1) begin : g_carry
                assign carry[gi+1] = nand2(n_ac, n_ac);
            end
        end
    endgenerate

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the RV523 core.
//   CLK       input              clock, all state on rising edge
//   RST       input              synchronous active-high reset, highest priority
//   LOAD      input              redirect from execute
//   TARGET    input  [XLEN-1:0]  redirect address, sampled when LOAD=1
//   READY     input              fetch accepts the offered PC this cycle
//   PC        output [XLEN-1:0]  current fetch address (registered)
//   VALID     output             PC offered to fetch (registered, =RUN state)
//   MISALIGN  output             last redirect had TARGET[1:0]!=0 (registered)
// PC[1:0] is hard-wired to zero; only PC[XLEN-1:2] is stored and incremented.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               XLEN         = RV523_XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RV523_RESET_VECTOR)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            LOAD,
    input  logic [XLEN-1:0] TARGET,
    input  logic            READY,
    output logic [XLEN-1:0] PC,
    output logic            VALID,
    output logic            MISALIGN
);

    localparam int W = XLEN - 2;

    pc_state_e      state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   pc_inc;
    logic [W-1:0]   step_sel;
    logic           misalign_q, misalign_d;
    logic           advance;
    logic           target_mis;

    pc_incr #(.W(W)) u_incr (
        .a_i (pc_q),
        .y_o (pc_inc)
    );

    // A transfer needs VALID (RUN) and READY; LOAD overrides it below,
    // so READY in HOLD never advances the PC.
    assign advance = (state_q == ST_RUN) & READY;

    // Two mux levels give the priority LOAD > transfer > hold.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_pc_mux
            assign step_sel[gi] = mux2_nand(advance, pc_q[gi], pc_inc[gi]);
            assign pc_d[gi]     = mux2_nand(LOAD, step_sel[gi], TARGET[gi+2]);
        end
    endgenerate

    // OR of the low target bits via De Morgan on a NAND.
    assign target_mis = nand2(~TARGET[1], ~TARGET[0]);
    assign misalign_d = mux2_nand(LOAD, misalign_q, target_mis);

    // HOLD lasts exactly one cycle after reset; RUN is absorbing until RST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_HOLD;
            pc_q       <= RESET_VECTOR[XLEN-1:2];
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign PC       = {pc_q, 2'b00};
    assign VALID    = (state_q == ST_RUN);
    assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        CLK;
    logic        RST;
    logic        LOAD;
    logic [31:0] TARGET;
    logic        READY;
    logic [31:0] PC;
    logic        VALID;
    logic        MISALIGN;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (LOAD),
        .TARGET   (TARGET),
        .READY    (READY),
        .PC       (PC),
        .VALID    (VALID),
        .MISALIGN (MISALIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic vec(input logic rst, input logic load, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] epc, input logic evalid,
                       input logic emis);
        exp_t e;
        @(negedge CLK);
        RST    = rst;
        LOAD   = load;
        TARGET = tgt;
        READY  = rdy;
        e.pc    = epc;
        e.valid = evalid;
        e.mis   = emis;
        q.push_back(e);
    endtask

    // Monitor: sample just after each rising edge, compare against scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                txn++;
                $display("txn %0d: PC=%08h VALID=%0b MISALIGN=%0b (exp %08h %0b %0b)",
                         txn, PC, VALID, MISALIGN, e.pc, e.valid, e.mis);
                checks++;
                if (PC !== e.pc) begin
                    failures++;
                    $display("FAIL pc txn %0d: got %08h expected %08h", txn, PC, e.pc);
                end
                checks++;
                if (VALID !== e.valid) begin
                    failures++;
                    $display("FAIL valid txn %0d: got %0b expected %0b", txn, VALID, e.valid);
                end
                checks++;
                if (MISALIGN !== e.mis) begin
                    failures++;
                    $display("FAIL misalign txn %0d: got %0b expected %0b", txn, MISALIGN, e.mis);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; LOAD = 1'b0; TARGET = 32'h0; READY = 1'b0;
        //   rst load target        rdy  exp_pc        v  mis
        // Reset, then release with READY held high.
        vec(1, 0, 32'h0,        1, 32'h0000_0000, 0, 0);
        vec(1, 0, 32'h0,        1, 32'h0000_0000, 0, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_0000, 1, 0);  // HOLD -> RUN, READY ignored
        vec(0, 0, 32'h0,        1, 32'h0000_0004, 1, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_0008, 1, 0);
        // Stall at 0x8 for three cycles.
        vec(0, 0, 32'h0,        0, 32'h0000_0008, 1, 0);
        vec(0, 0, 32'h0,        0, 32'h0000_0008, 1, 0);
        vec(0, 0, 32'h0,        0, 32'h0000_0008, 1, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_000C, 1, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_0010, 1, 0);
        // LOAD beats READY.
        vec(0, 1, 32'h0000_1000, 1, 32'h0000_1000, 1, 0);
        // Misaligned redirect, sticky through transfers and a stall.
        vec(0, 1, 32'h0000_2002, 1, 32'h0000_2000, 1, 1);
        vec(0, 0, 32'h0,        1, 32'h0000_2004, 1, 1);
        vec(0, 0, 32'h0,        1, 32'h0000_2008, 1, 1);
        vec(0, 0, 32'h0,        1, 32'h0000_200C, 1, 1);
        vec(0, 0, 32'h0,        1, 32'h0000_2010, 1, 1);
        vec(0, 0, 32'h0,        0, 32'h0000_2010, 1, 1);
        vec(0, 1, 32'h0000_0040, 0, 32'h0000_0040, 1, 0);  // aligned LOAD clears
        vec(0, 1, 32'h0000_0007, 0, 32'h0000_0004, 1, 1);  // bit0 and bit1 set
        vec(0, 1, 32'h0000_0041, 1, 32'h0000_0040, 1, 1);  // bit0 only
        vec(0, 1, 32'h0000_0040, 1, 32'h0000_0040, 1, 0);
        // Wrap-around.
        vec(0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_0000, 1, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_0004, 1, 0);
        // Reset mid-run with LOAD and READY pending.
        vec(0, 1, 32'h1234_0000, 0, 32'h1234_0000, 1, 0);
        vec(1, 1, 32'h0000_0006, 1, 32'h0000_0000, 0, 0);
        vec(0, 1, 32'h0000_3001, 1, 32'h0000_3000, 1, 1);  // LOAD applied in HOLD
        vec(0, 0, 32'h0,        1, 32'h0000_3004, 1, 1);
        // Reset clears a set MISALIGN; READY in HOLD does not advance.
        vec(1, 0, 32'h0,        0, 32'h0000_0000, 0, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_0000, 1, 0);
        vec(0, 0, 32'h0,        1, 32'h0000_0004, 1, 0);
        vec(0, 0, 32'h0,        0, 32'h0000_0004, 1, 0);

        @(negedge CLK);
        READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d entries left expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
